// File: rtl/mgt_rx_frame_decoder.sv
// Receive-side decoder for the 4-word trigger-link frame: aligns on the K-coded separator and rebuilds the GEM payload.
// Optional separator sequence check is enabled by defining MGT_RX_SEQ_CHECK_EN.
module mgt_rx_frame_decoder #(
    parameter int unsigned ALLOW_TTC_CHARS = 1,
    parameter int unsigned LOCK_FRAMES     = 4,
    parameter int unsigned UNLOCK_FRAMES   = 2
) (
    input  logic        clk_160,
    input  logic        reset,
    input  logic        rx_valid,
    input  logic [15:0] rx_data,
    input  logic [1:0]  rx_isk,
    output logic [55:0] gem_data,
    output logic        gem_valid,
    output logic        bc0_o,
    output logic        resync_o,
    output logic        overflow_o,
    output logic [1:0]  bxn_lsbs,
    output logic        locked,
    output logic        frame_err,
    output logic        seq_err,
    output logic [15:0] err_cnt
);

    localparam int unsigned PAY_W  = 56;
    localparam int unsigned PART_W = 40;
    localparam int unsigned POS_W  = 2;
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned ERR_W  = 16;

    localparam logic [CNT_W-1:0] LOCK_TGT   = CNT_W'(LOCK_FRAMES);
    localparam logic [CNT_W-1:0] UNLOCK_TGT = CNT_W'(UNLOCK_FRAMES);
    localparam logic             TTC_OK     = (ALLOW_TTC_CHARS != 0);
    localparam logic [ERR_W-1:0] ERR_MAX    = '1;

    typedef enum logic [1:0] {
        ST_SEARCH  = 2'd0,
        ST_LOCKING = 2'd1,
        ST_LOCKED  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [POS_W-1:0]   pos_q, pos_d;
    logic [CNT_W-1:0]   good_cnt_q, good_cnt_d;
    logic [CNT_W-1:0]   bad_cnt_q, bad_cnt_d;
    logic               frame_bad_q, frame_bad_d;
    logic [PART_W-1:0]  part_q, part_d;
    logic [1:0]         sep_bxn_q, sep_bxn_d;
    logic               sep_ttc_q, sep_ttc_d;
    logic               sep_bc0_q, sep_bc0_d;
    logic               sep_res_q, sep_res_d;
    logic               sep_ovf_q, sep_ovf_d;

    logic [PAY_W-1:0]   gem_data_d;
    logic               gem_valid_d;
    logic               bc0_d, resync_d, overflow_d;
    logic [1:0]         bxn_d;
    logic               locked_d;
    logic               frame_err_d;
    logic [ERR_W-1:0]   err_cnt_d;

    logic               sep_legal_c, sep_ttc_c, sep_bc0_c, sep_res_c, sep_ovf_c;
    logic [1:0]         sep_bxn_c;
    logic               word0_ok_c, word_ok_c, emit_c, seq_mis_c;
    logic [POS_W-1:0]   cap_pos_c;

    // Separator decode of the low byte
    always_comb begin
        sep_legal_c = 1'b1;
        sep_ttc_c   = 1'b0;
        sep_bc0_c   = 1'b0;
        sep_res_c   = 1'b0;
        sep_ovf_c   = 1'b0;
        sep_bxn_c   = 2'd0;
        case (rx_data[7:0])
            8'hBC: sep_bxn_c = 2'd0;
            8'hF7: sep_bxn_c = 2'd1;
            8'hFB: sep_bxn_c = 2'd2;
            8'hFD: sep_bxn_c = 2'd3;
            8'h1C: begin sep_ttc_c = 1'b1; sep_bc0_c = 1'b1; sep_legal_c = TTC_OK; end
            8'h3C: begin sep_ttc_c = 1'b1; sep_res_c = 1'b1; sep_legal_c = TTC_OK; end
            8'hFC: begin sep_ttc_c = 1'b1; sep_ovf_c = 1'b1; sep_legal_c = TTC_OK; end
            default: sep_legal_c = 1'b0;
        endcase
    end

    assign word0_ok_c = (rx_isk == 2'b01) && sep_legal_c;
    assign word_ok_c  = (pos_q == 2'd0) ? word0_ok_c : (rx_isk == 2'b00);
    assign cap_pos_c  = (state_q == ST_SEARCH) ? 2'd0 : pos_q;

`ifdef MGT_RX_SEQ_CHECK_EN
    logic seq_armed_q, seq_bad_q;

    // Plain separators must continue the bunch count; the first locked frame only sets the reference
    assign seq_mis_c = (state_q == ST_LOCKED) && (pos_q == 2'd0) && seq_armed_q &&
                       word0_ok_c && !sep_ttc_c && (sep_bxn_c != 2'(bxn_lsbs + 2'd1));

    always_ff @(posedge clk_160) begin
        if (reset) begin
            seq_armed_q <= 1'b0;
            seq_bad_q   <= 1'b0;
            seq_err     <= 1'b0;
        end else begin
            seq_err <= frame_err_d && seq_bad_q;
            if (rx_valid && (state_q == ST_LOCKED) && (pos_q == 2'd0))
                seq_bad_q <= seq_mis_c;
            if ((state_d == ST_LOCKED) && (state_q != ST_LOCKED))
                seq_armed_q <= 1'b0;
            else if (rx_valid && (state_q == ST_LOCKED) && (pos_q == 2'd3))
                seq_armed_q <= 1'b1;
        end
    end
`else
    assign seq_mis_c = 1'b0;
    assign seq_err   = 1'b0;
`endif

    // Next-state, capture and output decisions
    always_comb begin
        state_d     = state_q;
        pos_d       = pos_q;
        good_cnt_d  = good_cnt_q;
        bad_cnt_d   = bad_cnt_q;
        frame_bad_d = frame_bad_q;
        part_d      = part_q;
        sep_bxn_d   = sep_bxn_q;
        sep_ttc_d   = sep_ttc_q;
        sep_bc0_d   = sep_bc0_q;
        sep_res_d   = sep_res_q;
        sep_ovf_d   = sep_ovf_q;
        gem_data_d  = gem_data;
        bc0_d       = bc0_o;
        resync_d    = resync_o;
        overflow_d  = overflow_o;
        bxn_d       = bxn_lsbs;
        err_cnt_d   = err_cnt;
        gem_valid_d = 1'b0;
        frame_err_d = 1'b0;
        emit_c      = 1'b0;

        if (!rx_valid) begin
            state_d     = ST_SEARCH;
            pos_d       = 2'd0;
            good_cnt_d  = '0;
            bad_cnt_d   = '0;
            frame_bad_d = 1'b0;
        end else begin
            case (cap_pos_c)
                2'd0: begin
                    part_d[7:0] = rx_data[15:8];
                    sep_bxn_d   = sep_bxn_c;
                    sep_ttc_d   = sep_ttc_c;
                    sep_bc0_d   = sep_bc0_c;
                    sep_res_d   = sep_res_c;
                    sep_ovf_d   = sep_ovf_c;
                end
                2'd1: part_d[23:8]  = rx_data;
                2'd2: part_d[39:24] = rx_data;
                default: ;
            endcase

            case (state_q)
                ST_SEARCH: begin
                    if (word0_ok_c) begin
                        state_d    = ST_LOCKING;
                        pos_d      = 2'd1;
                        good_cnt_d = CNT_W'(1);
                    end
                end
                ST_LOCKING: begin
                    pos_d = 2'(pos_q + 2'd1);
                    if (!word_ok_c) begin
                        state_d    = ST_SEARCH;
                        pos_d      = 2'd0;
                        good_cnt_d = '0;
                    end else if (pos_q == 2'd3) begin
                        if (good_cnt_q >= LOCK_TGT) begin
                            state_d   = ST_LOCKED;
                            bad_cnt_d = '0;
                            emit_c    = 1'b1;
                        end else begin
                            good_cnt_d = CNT_W'(good_cnt_q + 1'b1);
                        end
                    end
                end
                ST_LOCKED: begin
                    pos_d = 2'(pos_q + 2'd1);
                    if (pos_q == 2'd0) begin
                        frame_bad_d = !word_ok_c || seq_mis_c;
                    end else if (pos_q != 2'd3) begin
                        frame_bad_d = frame_bad_q || !word_ok_c;
                    end else if (frame_bad_q || !word_ok_c) begin
                        frame_err_d = 1'b1;
                        frame_bad_d = 1'b0;
                        if (err_cnt != ERR_MAX)
                            err_cnt_d = ERR_W'(err_cnt + 1'b1);
                        if (CNT_W'(bad_cnt_q + 1'b1) >= UNLOCK_TGT) begin
                            state_d    = ST_SEARCH;
                            pos_d      = 2'd0;
                            bad_cnt_d  = '0;
                            good_cnt_d = '0;
                        end else begin
                            bad_cnt_d = CNT_W'(bad_cnt_q + 1'b1);
                        end
                    end else begin
                        bad_cnt_d = '0;
                        emit_c    = 1'b1;
                    end
                end
                default: begin
                    state_d = ST_SEARCH;
                    pos_d   = 2'd0;
                end
            endcase
        end

        // Word3 is still on the port, so it is merged straight into the payload
        if (emit_c) begin
            gem_valid_d = 1'b1;
            gem_data_d  = {rx_data, part_q};
            bc0_d       = sep_bc0_q;
            resync_d    = sep_res_q;
            overflow_d  = sep_ovf_q;
            bxn_d       = sep_ttc_q ? 2'(bxn_lsbs + 2'd1) : sep_bxn_q;
        end

        locked_d = (state_d == ST_LOCKED);
    end

    // State and output registers
    always_ff @(posedge clk_160) begin
        if (reset) begin
            state_q     <= ST_SEARCH;
            pos_q       <= '0;
            good_cnt_q  <= '0;
            bad_cnt_q   <= '0;
            frame_bad_q <= 1'b0;
            part_q      <= '0;
            sep_bxn_q   <= '0;
            sep_ttc_q   <= 1'b0;
            sep_bc0_q   <= 1'b0;
            sep_res_q   <= 1'b0;
            sep_ovf_q   <= 1'b0;
            gem_data    <= '0;
            gem_valid   <= 1'b0;
            bc0_o       <= 1'b0;
            resync_o    <= 1'b0;
            overflow_o  <= 1'b0;
            bxn_lsbs    <= '0;
            locked      <= 1'b0;
            frame_err   <= 1'b0;
            err_cnt     <= '0;
        end else begin
            state_q     <= state_d;
            pos_q       <= pos_d;
            good_cnt_q  <= good_cnt_d;
            bad_cnt_q   <= bad_cnt_d;
            frame_bad_q <= frame_bad_d;
            part_q      <= part_d;
            sep_bxn_q   <= sep_bxn_d;
            sep_ttc_q   <= sep_ttc_d;
            sep_bc0_q   <= sep_bc0_d;
            sep_res_q   <= sep_res_d;
            sep_ovf_q   <= sep_ovf_d;
            gem_data    <= gem_data_d;
            gem_valid   <= gem_valid_d;
            bc0_o       <= bc0_d;
            resync_o    <= resync_d;
            overflow_o  <= overflow_d;
            bxn_lsbs    <= bxn_d;
            locked      <= locked_d;
            frame_err   <= frame_err_d;
            err_cnt     <= err_cnt_d;
        end
    end

endmodule

// File: tb/tb_mgt_rx_frame_decoder.sv
// Scoreboard bench for mgt_rx_frame_decoder: directed frames push expected payloads, a negedge monitor pops and compares.
module tb_mgt_rx_frame_decoder;

    localparam logic [55:0] PAY = 56'h0123456789ABCD;
`ifdef MGT_RX_SEQ_CHECK_EN
    localparam int SEQ_EN = 1;
`else
    localparam int SEQ_EN = 0;
`endif

    typedef struct packed {
        logic [55:0] data;
        logic        bc0;
        logic        res;
        logic        ovf;
        logic [1:0]  bxn;
    } exp_t;

    logic        clk_160 = 1'b0;
    logic        reset;
    logic        rx_valid;
    logic [15:0] rx_data;
    logic [1:0]  rx_isk;

    logic [55:0] gem_data;
    logic        gem_valid, bc0_o, resync_o, overflow_o, locked, frame_err, seq_err;
    logic [1:0]  bxn_lsbs;
    logic [15:0] err_cnt;

    logic [55:0] n_gem_data;
    logic        n_gem_valid, n_bc0, n_resync, n_overflow, n_locked, n_frame_err, n_seq_err;
    logic [1:0]  n_bxn;
    logic [15:0] n_err_cnt;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   fe_seen  = 0;
    int   se_seen  = 0;

    always #3 clk_160 = ~clk_160;

    mgt_rx_frame_decoder u_dut (
        .clk_160   (clk_160),
        .reset     (reset),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data),
        .rx_isk    (rx_isk),
        .gem_data  (gem_data),
        .gem_valid (gem_valid),
        .bc0_o     (bc0_o),
        .resync_o  (resync_o),
        .overflow_o(overflow_o),
        .bxn_lsbs  (bxn_lsbs),
        .locked    (locked),
        .frame_err (frame_err),
        .seq_err   (seq_err),
        .err_cnt   (err_cnt)
    );

    // Same stream into a decoder that rejects the TTC separators
    mgt_rx_frame_decoder #(.ALLOW_TTC_CHARS(0)) u_dut_nottc (
        .clk_160   (clk_160),
        .reset     (reset),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data),
        .rx_isk    (rx_isk),
        .gem_data  (n_gem_data),
        .gem_valid (n_gem_valid),
        .bc0_o     (n_bc0),
        .resync_o  (n_resync),
        .overflow_o(n_overflow),
        .bxn_lsbs  (n_bxn),
        .locked    (n_locked),
        .frame_err (n_frame_err),
        .seq_err   (n_seq_err),
        .err_cnt   (n_err_cnt)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Monitor: every gem_valid must match the oldest expected frame
    always @(negedge clk_160) begin
        exp_t e;
        if (frame_err) fe_seen++;
        if (seq_err)   se_seen++;
        if (gem_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_gem_valid", 64'(gem_data), 64'(0));
            end else begin
                e = exp_q.pop_front();
                check("gem_frame", 64'({gem_data, bc0_o, resync_o, overflow_o, bxn_lsbs}), 64'(e));
                check("locked_with_gem", 64'(locked), 64'(1));
            end
        end
    end

    task automatic drive(input logic [15:0] d, input logic [1:0] k);
        @(posedge clk_160);
        #1;
        rx_data = d;
        rx_isk  = k;
    endtask

    task automatic push(input logic [7:0] sep, input logic [1:0] bxn);
        exp_t e;
        e.data = PAY;
        e.bc0  = (sep == 8'h1C);
        e.res  = (sep == 8'h3C);
        e.ovf  = (sep == 8'hFC);
        e.bxn  = bxn;
        exp_q.push_back(e);
    endtask

    // bad_pos 1..3 flips that word to K; prev_lock >= 0 checks locked as left by the previous frame
    task automatic send_frame(input logic [7:0] sep, input int bad_pos, input int emit,
                              input logic [1:0] bxn, input int prev_lock);
        logic [55:0] p;
        logic [1:0]  k[4];
        p = PAY;
        for (int i = 0; i < 4; i++) k[i] = (i == 0) ? 2'b01 : 2'b00;
        if (bad_pos >= 1 && bad_pos <= 3) k[bad_pos] = 2'b01;
        if (emit != 0) push(sep, bxn);
        drive({p[7:0], sep}, k[0]);
        if (prev_lock >= 0) check("locked_after_prev_frame", 64'(locked), 64'(prev_lock));
        drive(p[23:8], k[1]);
        drive(p[39:24], k[2]);
        drive(p[55:40], k[3]);
    endtask

    initial begin
        logic [55:0] p;
        p        = PAY;
        reset    = 1'b1;
        rx_valid = 1'b1;
        rx_data  = 16'hFFFC;
        rx_isk   = 2'b01;
        repeat (3) @(posedge clk_160);
        #1;
        check("rst_locked", 64'(locked), 64'(0));
        check("rst_gem_valid", 64'(gem_valid), 64'(0));
        check("rst_gem_data", 64'(gem_data), 64'(0));
        check("rst_bxn", 64'(bxn_lsbs), 64'(0));
        check("rst_err_cnt", 64'(err_cnt), 64'(0));
        check("rst_frame_err", 64'(frame_err), 64'(0));
        check("rst_flags", 64'({bc0_o, resync_o, overflow_o, seq_err}), 64'(0));
        reset = 1'b0;

        // Idle comma stream never locks
        repeat (40) drive(16'hFFFC, 2'b01);
        check("idle_locked", 64'(locked), 64'(0));
        check("idle_frame_err", 64'(fe_seen), 64'(0));
        repeat (2) drive(16'h0000, 2'b11);

        // Acquire lock: emitted from the 4th frame on
        send_frame(8'hBC, 0, 0, 2'd0, -1);
        send_frame(8'hF7, 0, 0, 2'd0, 0);
        send_frame(8'hFB, 0, 0, 2'd0, -1);
        send_frame(8'hFD, 0, 1, 2'd3, 0);
        send_frame(8'hBC, 0, 1, 2'd0, 1);
        send_frame(8'hF7, 0, 1, 2'd1, 1);
        send_frame(8'hFB, 0, 1, 2'd2, 1);
        send_frame(8'hFD, 0, 1, 2'd3, 1);

        // Single errored frame keeps lock
        send_frame(8'hBC, 2, 0, 2'd0, 1);
        send_frame(8'hBC, 0, 1, 2'd0, 1);
        check("err_cnt_one", 64'(err_cnt), 64'(1));
        check("frame_err_one", 64'(fe_seen), 64'(1));
        send_frame(8'hF7, 0, 1, 2'd1, 1);

        // Two errored frames drop lock, then relock after 4 good frames
        send_frame(8'hFB, 2, 0, 2'd0, 1);
        send_frame(8'hFD, 1, 0, 2'd0, 1);
        send_frame(8'hBC, 0, 0, 2'd0, 0);
        check("err_cnt_three", 64'(err_cnt), 64'(3));
        send_frame(8'hF7, 0, 0, 2'd0, -1);
        send_frame(8'hFB, 0, 0, 2'd0, -1);
        send_frame(8'hFD, 0, 1, 2'd3, 0);
        send_frame(8'hBC, 0, 1, 2'd0, 1);
        check("frame_err_three", 64'(fe_seen), 64'(3));

        // TTC separators carry flags and advance the bunch count
        send_frame(8'h1C, 0, 1, 2'd1, 1);
        send_frame(8'h3C, 0, 1, 2'd2, 1);
        send_frame(8'hFC, 0, 1, 2'd3, 1);
        send_frame(8'hBC, 0, 1, 2'd0, 1);
        check("ttc_err_cnt", 64'(err_cnt), 64'(3));
        check("nottc_err_cnt", 64'(n_err_cnt), 64'(5));
        check("nottc_locked", 64'(n_locked), 64'(0));

        // Sequence break on the FD frame (only errored with the sequence check built in)
        send_frame(8'hF7, 0, 1, 2'd1, 1);
        send_frame(8'hFB, 0, 1, 2'd2, 1);
        send_frame(8'hFD, 0, 1, 2'd3, 1);
        send_frame(8'hBC, 0, 1, 2'd0, 1);
        send_frame(8'hF7, 0, 1, 2'd1, 1);
        send_frame(8'hFD, 0, 1 - SEQ_EN, 2'd3, 1);
        send_frame(8'hFB, 0, 1, 2'd2, 1);
        check("seq_err_cnt", 64'(err_cnt), 64'(3 + SEQ_EN));
        check("seq_err_seen", 64'(se_seen), 64'(SEQ_EN));
        check("seq_frame_err", 64'(fe_seen), 64'(3 + SEQ_EN));

        // rx_valid drop mid-frame
        drive({p[7:0], 8'hFD}, 2'b01);
        drive(p[23:8], 2'b00);
        @(posedge clk_160);
        #1;
        rx_valid = 1'b0;
        rx_data  = p[39:24];
        rx_isk   = 2'b00;
        @(posedge clk_160);
        #1;
        rx_valid = 1'b1;
        rx_data  = p[55:40];
        check("valid_drop_locked", 64'(locked), 64'(0));
        send_frame(8'hBC, 0, 0, 2'd0, 0);
        send_frame(8'hF7, 0, 0, 2'd0, -1);
        send_frame(8'hFB, 0, 0, 2'd0, -1);
        send_frame(8'hFD, 0, 1, 2'd3, 0);
        send_frame(8'hBC, 0, 1, 2'd0, 1);
        check("valid_drop_err_cnt", 64'(err_cnt), 64'(3 + SEQ_EN));

        // Reset mid-frame clears everything
        drive({p[7:0], 8'hF7}, 2'b01);
        drive(p[23:8], 2'b00);
        @(posedge clk_160);
        #1;
        reset   = 1'b1;
        rx_data = p[39:24];
        @(posedge clk_160);
        #1;
        check("midrst_locked", 64'(locked), 64'(0));
        check("midrst_err_cnt", 64'(err_cnt), 64'(0));
        check("midrst_gem", 64'({gem_data, bxn_lsbs}), 64'(0));
        reset = 1'b0;
        repeat (6) drive(16'h0000, 2'b11);
        check("scoreboard_drained", 64'(exp_q.size()), 64'(0));
        check("final_frame_err", 64'(fe_seen), 64'(3 + SEQ_EN));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
